// File: rtl/div_seq_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
package div_seq_pkg;

  localparam int unsigned CNT_W = 6;

  localparam logic        DIV_START = 1'b1;
  localparam logic        DIV_STOP  = 1'b0;
  localparam logic        ENABLE    = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, result pulsed
// for one cycle into the HI (remainder) / LO (quotient) write port.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_div_i,
  input  logic [DIV_W-1:0] opdata1_i,
  input  logic [DIV_W-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             stallreq_o,
  output logic             ready_o,
  output logic             whilo_o,
  output logic [DIV_W-1:0] hi_o,
  output logic [DIV_W-1:0] lo_o
);

  localparam int unsigned WR_W = 2 * DIV_W + 1;

  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] x, input logic en);
    return en ? (DIV_W'(0) - x) : x;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WR_W-1:0]  work_q, work_d;
  logic [DIV_W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic             signed_q, signed_d;
  logic             ready_q, ready_d, whilo_q, whilo_d;
  logic [DIV_W-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [DIV_W-1:0] mag2;
  logic [WR_W-1:0]  shifted, step;
  logic [DIV_W:0]   diff;
  logic [DIV_W-1:0] q_fin, r_fin;
  logic             unused_bits;

  // One restoring step: shift {rem,dividend} left, keep the trial subtract if it did not borrow.
  assign mag2    = neg_if(op2_q, signed_q & op2_q[DIV_W-1]);
  assign shifted = {work_q[WR_W-2:0], 1'b0};
  assign diff    = shifted[WR_W-1:DIV_W] - {1'b0, mag2};
  assign step    = diff[DIV_W] ? shifted : {diff, shifted[DIV_W-1:1], 1'b1};
  assign q_fin   = neg_if(step[DIV_W-1:0], signed_q & (op1_q[DIV_W-1] ^ op2_q[DIV_W-1]));
  assign r_fin   = neg_if(step[2*DIV_W-1:DIV_W], signed_q & op1_q[DIV_W-1]);

  // Top working bit is always shifted out; only the dividend sign is needed after latching.
  assign unused_bits = ^{work_q[WR_W-1], step[WR_W-1], shifted[0], op1_q[DIV_W-2:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    signed_d   = signed_q;
    ready_d    = 1'b0;
    whilo_d    = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    stallreq_o = DIV_STOP;
    unique case (state_q)
      DIV_FREE: begin
        stallreq_o = start_i;
        if (start_i == DIV_START && !annul_i) begin
          op1_d    = opdata1_i;
          op2_d    = opdata2_i;
          signed_d = signed_div_i;
          cnt_d    = '0;
          work_d   = WR_W'(neg_if(opdata1_i, signed_div_i & opdata1_i[DIV_W-1]));
          state_d  = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        stallreq_o = DIV_START;
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d = DIV_END;
          ready_d = ENABLE;
          whilo_d = ENABLE;
          hi_d    = DIV_W'(ZERO_WORD);
          lo_d    = DIV_W'(ZERO_WORD);
        end
      end
      DIV_ON: begin
        stallreq_o = DIV_START;
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          work_d = step;
          cnt_d  = CNT_W'(cnt_q + 1'b1);
          if (cnt_q == CNT_W'(DIV_W - 1)) begin
            state_d = DIV_END;
            ready_d = ENABLE;
            whilo_d = ENABLE;
            hi_d    = r_fin;
            lo_d    = q_fin;
          end
        end
      end
      DIV_END: state_d = DIV_FREE;
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      signed_q <= 1'b0;
      ready_q  <= 1'b0;
      whilo_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      signed_q <= signed_d;
      ready_q  <= ready_d;
      whilo_q  <= whilo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign ready_o = ready_q;
  assign whilo_o = whilo_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Randomised and directed bench for div_seq against a plain-arithmetic reference.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        stallreq_o;
  logic        ready_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad   = 0;

  div_seq #(.DIV_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .stallreq_o  (stallreq_o),
    .ready_o     (ready_o),
    .whilo_o     (whilo_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: MIPS DIV/DIVU semantics, divide-by-zero gives zeros.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
    longint sa, sb;
    if (b == 32'd0) begin
      h = 32'd0; l = 32'd0;
    end else if (!sgn) begin
      l = a / b; h = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      l  = 32'(sa / sb);
      h  = 32'(sa % sb);
    end
  endfunction

  // Launch one divide, scribble on inputs while busy, and report what the DUT did.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output int lat,
                        output logic stall0, output int stall_gaps, output logic wh,
                        output logic stall_end, output logic post_pulse, output logic hold);
    bit done = 0;
    h = '0; l = '0; lat = 0; stall_gaps = 0; wh = 0; stall_end = 1; post_pulse = 1; hold = 0;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    #1 stall0 = stallreq_o;
    @(posedge clk);
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      if (ready_o) begin
        lat = cyc; h = hi_o; l = lo_o; wh = whilo_o; stall_end = stallreq_o;
        done = 1; start_i = 1'b0;
      end else begin
        if (stallreq_o !== 1'b1) stall_gaps++;
        start_i      = 1'($urandom_range(0, 1));
        signed_div_i = 1'($urandom_range(0, 1));
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
      end
    end
    start_i = 1'b0;
    @(negedge clk);
    post_pulse = ready_o | whilo_o;
    hold       = (hi_o === h) && (lo_o === l);
  endtask

  task automatic run_and_check(input string name, input bit sgn, input logic [31:0] a,
                               input logic [31:0] b);
    logic [31:0] eh, el, h, l;
    int lat, gaps, elat;
    logic s0, wh, se, pp, hd;
    ref_div(sgn, a, b, eh, el);
    elat = (b == 32'd0) ? 2 : 33;
    do_div(sgn, a, b, h, l, lat, s0, gaps, wh, se, pp, hd);
    total++; if (lat !== elat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, elat); end
    total++; if (h !== eh) begin bad++; $display("FAIL %s hi a=%h b=%h s=%0d got=%h exp=%h", name, a, b, sgn, h, eh); end
    total++; if (l !== el) begin bad++; $display("FAIL %s lo a=%h b=%h s=%0d got=%h exp=%h", name, a, b, sgn, l, el); end
    total++; if (wh !== 1'b1) begin bad++; $display("FAIL %s whilo got=%b exp=1", name, wh); end
    total++; if (s0 !== 1'b1) begin bad++; $display("FAIL %s stall_at_start got=%b exp=1", name, s0); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL %s stall_busy_gaps got=%0d exp=0", name, gaps); end
    total++; if (se !== 1'b0) begin bad++; $display("FAIL %s stall_in_end got=%b exp=0", name, se); end
    total++; if (pp !== 1'b0) begin bad++; $display("FAIL %s pulse_after_end got=%b exp=0", name, pp); end
    total++; if (hd !== 1'b1) begin bad++; $display("FAIL %s result_hold got=%h/%h exp=%h/%h", name, hi_o, lo_o, h, l); end
  endtask

  task automatic test_reset;
    rst = 1'b0; start_i = 0; annul_i = 0; signed_div_i = 0; opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    total++; if ({ready_o, whilo_o, stallreq_o, hi_o, lo_o} !== 67'd0) begin
      bad++; $display("FAIL reset_outputs got=%b%b%b %h %h exp=all zero", ready_o, whilo_o, stallreq_o, hi_o, lo_o);
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({ready_o, whilo_o, stallreq_o} !== 3'b000) begin
      bad++; $display("FAIL reset_release got=%b%b%b exp=000", ready_o, whilo_o, stallreq_o);
    end
  endtask

  task automatic test_directed;
    run_and_check("divu_100_7", 1'b0, 32'd100, 32'd7);
    run_and_check("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_and_check("div_5_0", 1'b1, 32'd5, 32'd0);
    run_and_check("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_and_check("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run_and_check("divu_small_big", 1'b0, 32'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    bit sgn;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom;
        default: b = 32'(-int'($urandom_range(1, 15)));
      endcase
      run_and_check("random", sgn, a, b);
    end
  endtask

  task automatic test_annul;
    logic [31:0] h0, l0;
    int pulses = 0;
    h0 = hi_o; l0 = lo_o;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    total++; if ({stallreq_o, ready_o, whilo_o} !== 3'b000) begin
      bad++; $display("FAIL annul_idle got=%b%b%b exp=000", stallreq_o, ready_o, whilo_o);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (whilo_o || ready_o) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL annul_no_pulse got=%0d exp=0", pulses); end
    total++; if (hi_o !== h0 || lo_o !== l0) begin
      bad++; $display("FAIL annul_hold got=%h/%h exp=%h/%h", hi_o, lo_o, h0, l0);
    end
    run_and_check("after_annul", 1'b0, 32'd1000, 32'd3);

    // Annul while idle blocks acceptance.
    pulses = 0;
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    #1;
    total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL annul_idle_stall got=%b exp=0", stallreq_o); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (whilo_o || stallreq_o) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL annul_idle_accept got=%0d exp=0", pulses); end
  endtask

  task automatic test_async_reset;
    run_and_check("pre_reset", 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int cyc = 2; cyc <= 15; cyc++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if ({ready_o, whilo_o, stallreq_o, hi_o, lo_o} !== 67'd0) begin
      bad++; $display("FAIL async_reset got=%b%b%b %h %h exp=all zero", ready_o, whilo_o, stallreq_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b1;
    run_and_check("divu_9_4", 1'b0, 32'd9, 32'd4);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-low reset; rst==0 resets immediately.
REQ-003 SHALL have ports: start_i  in  1  divide request, sampled in IDLE.
REQ-004 SHALL have ports: signed_div_i  in  1  1=DIV (signed), 0=DIVU.
REQ-005 SHALL have ports: opdata1_i  in  32  dividend.
REQ-006 SHALL have ports: opdata2_i  in  32  divisor.
REQ-007 SHALL have ports: annul_i  in  1  cancel in-flight divide (flush/exception).
REQ-008 SHALL have ports: stallreq_o  out  1  pipeline stall request.
REQ-009 SHALL have ports: ready_o  out  1  result valid, one-cycle pulse.
REQ-010 SHALL have ports: whilo_o  out  1  HI/LO write enable to the HI/LO register file, one-cycle pulse.
REQ-011 SHALL have ports: hi_o / lo_o  out  32 each  remainder / quotient.
REQ-012 Parameter: DIV_W, default 32, operand width; only 32 is required to be supported.

Function
REQ-013 States SHALL be IDLE, BYZERO, ON, END; reset state IDLE.
REQ-014 IDLE with start_i=1 SHALL latch signed_div_i, opdata1_i, opdata2_i, then go to BYZERO if opdata2_i==0, else ON.
REQ-015 stallreq_o SHALL be combinationally 1 in IDLE when start_i=1, and in BYZERO and ON; 0 in IDLE (start_i=0) and END.
REQ-016 ON SHALL resolve one quotient bit per cycle, MSB first, by restoring division (33-bit trial subtract) on operand magnitudes; after exactly 32 ON cycles go to END.
REQ-017 BYZERO SHALL last one cycle, force quotient=0 and remainder=0, then go to END.
REQ-018 END SHALL last one cycle: ready_o=1, whilo_o=1, hi_o=remainder, lo_o=quotient; next state IDLE.
REQ-019 Latency: start sampled at edge 0 -> END at cycle 33 (nonzero divisor) or cycle 2 (zero divisor).
REQ-020 Signed mode: magnitudes via two's-complement negation; quotient negated iff operand signs differ; remainder takes the dividend's sign; 0x80000000/0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-021 Unsigned mode: operands used as-is, no result negation.
REQ-022 start_i in BYZERO/ON/END SHALL be ignored; latched operands SHALL not change.
REQ-023 annul_i=1 in BYZERO or ON SHALL return to IDLE next edge with no ready_o/whilo_o pulse; annul_i in IDLE SHALL suppress acceptance of start_i; annul_i in END SHALL have no effect.
REQ-024 Outside END, ready_o=0 and whilo_o=0; hi_o/lo_o SHALL hold the last result.

Reset
REQ-025 rst==0 SHALL asynchronously force: state=IDLE, ready_o=0, whilo_o=0, hi_o=0, lo_o=0, iteration counter=0, and clear the latched operands.
REQ-026 Reset during ON/BYZERO SHALL abort without any write pulse; first accept SHALL occur on the first edge with rst==1 and start_i=1.

Structure
REQ-027 State encodings (DivFree/DivByZero/DivOn/DivEnd), DivStart/DivStop, and the ZeroWord/Enable constants SHALL live in the shared defines.v.
REQ-028 Single module; no sub-module; 6-bit iteration counter and 65-bit working register {remainder,dividend} internal.
REQ-029 whilo_o/hi_o/lo_o SHALL connect directly to the HI/LO register file write port (via the pipeline's WB path).

Verification
REQ-030 DIVU 100/7 -> cycle 33: ready_o=whilo_o=1, hi_o=2, lo_o=14; stallreq_o high for cycles 0-32.
REQ-031 DIV 0xFFFFFFF9(-7)/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-032 DIV 5/0 -> BYZERO at cycle 1, END at cycle 2, hi_o=lo_o=0, whilo_o pulse.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-034 DIVU 1000/3, annul_i at cycle 10 -> IDLE at cycle 11, no whilo_o, stallreq_o=0; a new start then completes normally.
REQ-035 rst=0 asynchronously at cycle 15 of a divide -> all outputs 0 immediately; after release, DIVU 9/4 -> hi_o=1, lo_o=2.
